// File: rtl/asconp_sched.sv
// asconp_sched: sequencing controller for the Ascon permutation.
// Holds the 320-bit state, feeds "rounds remaining" to an UROL-round core
// and hands the permuted state back through a valid/ready handshake.
// Optional feature macro: ASCONP_SCHED_PERF_CNT_EN (adds perm_cnt / busy_cyc).

// Combinational core: UROL consecutive Ascon rounds per call.
module asconp_core #(
  parameter int UROL = 1
) (
  input  logic [319:0] state_i,
  input  logic [3:0]   rounds_i,   // rounds remaining before this cycle
  output logic [319:0] state_o
);

  function automatic logic [63:0] ror64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // One Ascon round; the round index is derived from the rounds remaining,
  // so p12/p8/p6 all share the tail of the same constant schedule.
  function automatic logic [319:0] ascon_round(input logic [319:0] s,
                                               input logic [3:0]   rem);
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;
    logic [3:0]  r;
    r  = 4'd12 - rem;
    x0 = s[319:256];
    x1 = s[255:192];
    x2 = s[191:128];
    x3 = s[127:64];
    x4 = s[63:0];
    // Round constant (15 - r) || r in the low byte of x2.
    x2 = x2 ^ {56'd0, ~r, r};
    // Bitsliced 5-bit S-box.
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    // Linear diffusion layer.
    x0 = x0 ^ ror64(x0, 19) ^ ror64(x0, 28);
    x1 = x1 ^ ror64(x1, 61) ^ ror64(x1, 39);
    x2 = x2 ^ ror64(x2, 1)  ^ ror64(x2, 6);
    x3 = x3 ^ ror64(x3, 10) ^ ror64(x3, 17);
    x4 = x4 ^ ror64(x4, 7)  ^ ror64(x4, 41);
    return {x0, x1, x2, x3, x4};
  endfunction

  logic [319:0] stage [UROL+1];

  assign stage[0] = state_i;

  for (genvar g = 0; g < UROL; g++) begin : g_round
    assign stage[g+1] = ascon_round(stage[g], rounds_i - 4'(g));
  end

  assign state_o = stage[UROL];

endmodule

module asconp_sched #(
  parameter int UROL = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   in_rounds,
  input  logic [319:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [319:0] out_state,
  output logic         out_err,
`ifdef ASCONP_SCHED_PERF_CNT_EN
  output logic [31:0]  perm_cnt,
  output logic [31:0]  busy_cyc,
`endif
  output logic         busy
);

  if (!(UROL == 1 || UROL == 2 || UROL == 3 || UROL == 4 || UROL == 6)) begin : g_bad_urol
    $fatal(1, "asconp_sched: UROL must be one of 1, 2, 3, 4, 6");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } fsm_e;

  fsm_e         fsm_q, fsm_d;
  logic [319:0] state_q, state_d;
  logic [3:0]   round_cnt_q, round_cnt_d;
  logic         err_q, err_d;
  logic [319:0] core_out;
  logic         req_legal;

  asconp_core #(.UROL(UROL)) u_core (
    .state_i  (state_q),
    .rounds_i (round_cnt_q),
    .state_o  (core_out)
  );

  // A request is legal when 1 <= R <= 12 and the core lands exactly on zero.
  assign req_legal = (in_rounds != 4'd0) && (in_rounds <= 4'd12) &&
                     ((in_rounds % 4'(UROL)) == 4'd0);

  // Next-state logic for the FSM, state register, round counter and error flag.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    fsm_d       = fsm_q;
    state_d     = state_q;
    round_cnt_d = round_cnt_q;
    err_d       = err_q;
    unique case (fsm_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d     = in_state;
          round_cnt_d = in_rounds;
          if (req_legal) begin
            fsm_d = S_RUN;
            err_d = 1'b0;
          end else begin
            fsm_d = S_DONE;
            err_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        state_d     = core_out;
        round_cnt_d = round_cnt_q - 4'(UROL);
        if (round_cnt_q == 4'(UROL)) fsm_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          fsm_d = S_IDLE;
          err_d = 1'b0;
        end
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  // State register update with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      fsm_q       <= S_IDLE;
      // NOTE: the wide state register is reset as well, so an aborted run
      // leaves no residue visible on out_state.
      state_q     <= '0;
      round_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      round_cnt_q <= round_cnt_d;
      err_q       <= err_d;
    end
  end

  assign in_ready  = (fsm_q == S_IDLE);
  assign out_valid = (fsm_q == S_DONE);
  assign busy      = (fsm_q != S_IDLE);
  assign out_err   = err_q;
  assign out_state = state_q;

`ifdef ASCONP_SCHED_PERF_CNT_EN
  logic [31:0] perm_cnt_q, busy_cyc_q;

  // Count successful result transfers and cycles spent iterating the core.
  always_ff @(posedge clk) begin
    if (rst) begin
      perm_cnt_q <= '0;
      busy_cyc_q <= '0;
    end else begin
      if (fsm_q == S_DONE && out_ready && !err_q) perm_cnt_q <= perm_cnt_q + 32'd1;
      if (fsm_q == S_RUN) busy_cyc_q <= busy_cyc_q + 32'd1;
    end
  end

  assign perm_cnt = perm_cnt_q;
  assign busy_cyc = busy_cyc_q;
`endif

endmodule

// File: tb/tb_asconp_sched.sv
// Directed testbench for asconp_sched with three instances (UROL = 1, 2, 4)
// and an independent S-box-table reference model of Ascon-p.
module tb_asconp_sched;

  logic         clk = 1'b0;
  logic         rst;
  logic         req;
  logic         out_ready;
  logic [3:0]   in_rounds;
  logic [319:0] in_state;
  int           sel;

  logic         in_valid_u1, in_ready_u1, out_valid_u1, out_err_u1, busy_u1;
  logic         in_valid_u2, in_ready_u2, out_valid_u2, out_err_u2, busy_u2;
  logic         in_valid_u4, in_ready_u4, out_valid_u4, out_err_u4, busy_u4;
  logic [319:0] out_state_u1, out_state_u2, out_state_u4;
`ifdef ASCONP_SCHED_PERF_CNT_EN
  logic [31:0]  perm_cnt_u1, busy_cyc_u1, perm_cnt_u2, busy_cyc_u2, perm_cnt_u4, busy_cyc_u4;
`endif

  logic         v_in_ready, v_out_valid, v_out_err, v_busy;
  logic [319:0] v_out_state;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign in_valid_u1 = req && (sel == 1);
  assign in_valid_u2 = req && (sel == 2);
  assign in_valid_u4 = req && (sel == 4);

  asconp_sched #(.UROL(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_u1), .in_ready(in_ready_u1),
    .in_rounds(in_rounds), .in_state(in_state), .out_valid(out_valid_u1),
    .out_ready(out_ready), .out_state(out_state_u1), .out_err(out_err_u1),
`ifdef ASCONP_SCHED_PERF_CNT_EN
    .perm_cnt(perm_cnt_u1), .busy_cyc(busy_cyc_u1),
`endif
    .busy(busy_u1)
  );

  asconp_sched #(.UROL(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid_u2), .in_ready(in_ready_u2),
    .in_rounds(in_rounds), .in_state(in_state), .out_valid(out_valid_u2),
    .out_ready(out_ready), .out_state(out_state_u2), .out_err(out_err_u2),
`ifdef ASCONP_SCHED_PERF_CNT_EN
    .perm_cnt(perm_cnt_u2), .busy_cyc(busy_cyc_u2),
`endif
    .busy(busy_u2)
  );

  asconp_sched #(.UROL(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid_u4), .in_ready(in_ready_u4),
    .in_rounds(in_rounds), .in_state(in_state), .out_valid(out_valid_u4),
    .out_ready(out_ready), .out_state(out_state_u4), .out_err(out_err_u4),
`ifdef ASCONP_SCHED_PERF_CNT_EN
    .perm_cnt(perm_cnt_u4), .busy_cyc(busy_cyc_u4),
`endif
    .busy(busy_u4)
  );

  // View of the currently selected instance.
  always_comb begin
    v_in_ready  = in_ready_u1;
    v_out_valid = out_valid_u1;
    v_out_err   = out_err_u1;
    v_busy      = busy_u1;
    v_out_state = out_state_u1;
    if (sel == 2) begin
      v_in_ready  = in_ready_u2;
      v_out_valid = out_valid_u2;
      v_out_err   = out_err_u2;
      v_busy      = busy_u2;
      v_out_state = out_state_u2;
    end else if (sel == 4) begin
      v_in_ready  = in_ready_u4;
      v_out_valid = out_valid_u4;
      v_out_err   = out_err_u4;
      v_busy      = busy_u4;
      v_out_state = out_state_u4;
    end
  end

  // ---------------- reference model ----------------
  localparam bit [7:0] RC_TAB [0:11] = '{8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
                                         8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b};
  localparam bit [4:0] SBOX [0:31] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

  function automatic logic [63:0] rot(input logic [63:0] v, input int n);
    logic [63:0] o;
    for (int i = 0; i < 64; i++) o[i] = v[(i + n) % 64];
    return o;
  endfunction

  function automatic logic [319:0] ref_perm(input logic [319:0] s, input int r);
    logic [63:0] x0, x1, x2, x3, x4, y0, y1, y2, y3, y4;
    logic [4:0]  idx, o;
    {x0, x1, x2, x3, x4} = s;
    for (int i = 0; i < r; i++) begin
      x2 = x2 ^ {56'd0, RC_TAB[12 - r + i]};
      for (int b = 0; b < 64; b++) begin
        idx   = {x0[b], x1[b], x2[b], x3[b], x4[b]};
        o     = SBOX[idx];
        y0[b] = o[4];
        y1[b] = o[3];
        y2[b] = o[2];
        y3[b] = o[1];
        y4[b] = o[0];
      end
      x0 = y0 ^ rot(y0, 19) ^ rot(y0, 28);
      x1 = y1 ^ rot(y1, 61) ^ rot(y1, 39);
      x2 = y2 ^ rot(y2, 1)  ^ rot(y2, 6);
      x3 = y3 ^ rot(y3, 10) ^ rot(y3, 17);
      x4 = y4 ^ rot(y4, 7)  ^ rot(y4, 41);
    end
    return {x0, x1, x2, x3, x4};
  endfunction

  function automatic logic [319:0] rand_state();
    logic [319:0] s;
    for (int i = 0; i < 10; i++) s[i*32 +: 32] = $urandom;
    return s;
  endfunction

  // ---------------- drivers ----------------
  // Waits (bounded) for in_ready on instance s, then presents one request.
  task automatic send(input int s, input logic [3:0] r, input logic [319:0] st);
    int n;
    sel = s;
    #1;
    n = 0;
    while (v_in_ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (v_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL send_ready u%0d: in_ready=%b required 1", s, v_in_ready);
    end
    in_rounds = r;
    in_state  = st;
    req       = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  // Counts clock edges until out_valid; -1 when the bound expires.
  task automatic wait_valid(output int n);
    n = 0;
    while (v_out_valid !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (v_out_valid !== 1'b1) n = -1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; req = 1'b0; out_ready = 1'b1; sel = 1;
    in_rounds = 4'd0; in_state = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({in_ready_u1, in_ready_u2, in_ready_u4} !== 3'b111) begin
      failures++;
      $display("FAIL reset_in_ready: got %b required 111", {in_ready_u1, in_ready_u2, in_ready_u4});
    end
    checks++;
    if ({out_valid_u1, out_err_u1, busy_u1, out_valid_u4, busy_u4} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags: valid/err/busy got %b required 00000",
               {out_valid_u1, out_err_u1, busy_u1, out_valid_u4, busy_u4});
    end
    checks++;
    if (out_state_u1 !== 320'h0) begin
      failures++;
      $display("FAIL reset_state: got %h required 0", out_state_u1);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready_u1 !== 1'b1 || busy_u1 !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_idle: in_ready=%b busy=%b required 1 0", in_ready_u1, busy_u1);
    end
  endtask

  task automatic test_p12();
    logic [319:0] exp;
    int n;
    exp = ref_perm(320'h0, 12);
    out_ready = 1'b1;
    send(1, 4'd12, 320'h0);
    checks++;
    if (v_in_ready !== 1'b0 || v_busy !== 1'b1) begin
      failures++;
      $display("FAIL p12_run_flags: in_ready=%b busy=%b required 0 1", v_in_ready, v_busy);
    end
    wait_valid(n);
    checks++;
    if (n != 12) begin
      failures++;
      $display("FAIL p12_latency: got %0d edges required 12", n);
    end
    checks++;
    if (v_out_state !== exp || v_out_err !== 1'b0) begin
      failures++;
      $display("FAIL p12_result: got %h err=%b required %h err=0", v_out_state, v_out_err, exp);
    end
    @(posedge clk); #1;
    checks++;
    if (v_in_ready !== 1'b1 || v_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL p12_return_idle: in_ready=%b out_valid=%b required 1 0", v_in_ready, v_out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [319:0] sa, sb, ea, eb;
    int n;
    sa = rand_state();
    sb = rand_state();
    ea = ref_perm(sa, 8);
    eb = ref_perm(sb, 6);
    out_ready = 1'b1;
    send(2, 4'd8, sa);
    wait_valid(n);
    checks++;
    if (n != 4) begin
      failures++;
      $display("FAIL p8_u2_latency: got %0d edges required 4", n);
    end
    checks++;
    if (v_out_state !== ea || v_out_err !== 1'b0) begin
      failures++;
      $display("FAIL p8_u2_result: got %h err=%b required %h err=0", v_out_state, v_out_err, ea);
    end
    send(2, 4'd6, sb);
    wait_valid(n);
    checks++;
    if (n != 3) begin
      failures++;
      $display("FAIL p6_u2_latency: got %0d edges required 3", n);
    end
    checks++;
    if (v_out_state !== eb || v_out_err !== 1'b0) begin
      failures++;
      $display("FAIL p6_u2_result: got %h err=%b required %h err=0", v_out_state, v_out_err, eb);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_illegal();
    logic [319:0] st;
    int n;
    logic [3:0] bad [3];
    bad[0] = 4'd6; bad[1] = 4'd0; bad[2] = 4'd15;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      st = rand_state();
      send(4, bad[i], st);
      wait_valid(n);
      checks++;
      if (n != 0) begin
        failures++;
        $display("FAIL illegal_latency R=%0d: got %0d edges required 0", bad[i], n);
      end
      checks++;
      if (v_out_err !== 1'b1 || v_out_state !== st) begin
        failures++;
        $display("FAIL illegal_result R=%0d: err=%b state=%h required err=1 state=%h",
                 bad[i], v_out_err, v_out_state, st);
      end
    end
    st = rand_state();
    send(4, 4'd12, st);
    wait_valid(n);
    checks++;
    if (n != 3) begin
      failures++;
      $display("FAIL p12_u4_latency: got %0d edges required 3", n);
    end
    checks++;
    if (v_out_err !== 1'b0 || v_out_state !== ref_perm(st, 12)) begin
      failures++;
      $display("FAIL p12_u4_result: err=%b state=%h required err=0 state=%h",
               v_out_err, v_out_state, ref_perm(st, 12));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic [319:0] st, exp;
    int n, bad_cycles;
    st  = rand_state();
    exp = ref_perm(st, 12);
    out_ready = 1'b0;
    send(1, 4'd12, st);
    wait_valid(n);
    checks++;
    if (n != 12) begin
      failures++;
      $display("FAIL bp_latency: got %0d edges required 12", n);
    end
    bad_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      req       = 1'b1;
      in_rounds = 4'd8;
      in_state  = ~st ^ 320'(i);
      @(posedge clk); #1;
      if (v_out_valid !== 1'b1 || v_out_state !== exp || v_in_ready !== 1'b0 || v_out_err !== 1'b0)
        bad_cycles++;
    end
    checks++;
    if (bad_cycles != 0) begin
      failures++;
      $display("FAIL bp_hold: %0d of 20 stalled cycles lost valid/state/ready, required 0", bad_cycles);
    end
    req       = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (v_out_valid !== 1'b0 || v_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b required 0 1", v_out_valid, v_in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (v_out_valid !== 1'b0 || v_busy !== 1'b0) begin
      failures++;
      $display("FAIL bp_single_transfer: out_valid=%b busy=%b required 0 0", v_out_valid, v_busy);
    end
  endtask

  task automatic test_abort();
    int spurious;
    out_ready = 1'b1;
    send(1, 4'd12, rand_state());
    repeat (4) begin
      @(posedge clk); #1;
    end
    checks++;
    if (v_busy !== 1'b1 || v_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL abort_in_run: busy=%b out_valid=%b required 1 0", v_busy, v_out_valid);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (v_out_valid !== 1'b0 || v_busy !== 1'b0 || v_in_ready !== 1'b1 ||
        v_out_err !== 1'b0 || v_out_state !== 320'h0) begin
      failures++;
      $display("FAIL abort_reset: valid=%b busy=%b ready=%b err=%b state=%h required 0 0 1 0 0",
               v_out_valid, v_busy, v_in_ready, v_out_err, v_out_state);
    end
    spurious = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (v_out_valid !== 1'b0) spurious++;
    end
    checks++;
    if (spurious != 0) begin
      failures++;
      $display("FAIL abort_no_valid: %0d cycles with out_valid, required 0", spurious);
    end
  endtask

`ifdef ASCONP_SCHED_PERF_CNT_EN
  task automatic test_perf();
    int n;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(1, 4'd12, rand_state());
      wait_valid(n);
    end
    send(1, 4'd0, rand_state());
    wait_valid(n);
    @(posedge clk); #1;
    checks++;
    if (perm_cnt_u1 !== 32'd3) begin
      failures++;
      $display("FAIL perf_perm_cnt: got %0d required 3", perm_cnt_u1);
    end
    checks++;
    if (busy_cyc_u1 !== 32'd36) begin
      failures++;
      $display("FAIL perf_busy_cyc: got %0d required 36", busy_cyc_u1);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_p12();
    test_back_to_back();
    test_illegal();
    test_backpressure();
    test_abort();
`ifdef ASCONP_SCHED_PERF_CNT_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
